// File: rtl/axil_resp_pkg.sv
// ---------------------------------------------------------------------------
// axil_resp_pkg
// Shared definitions for the AXI4-Lite register responder:
//   - REG_WIDTH      : width of every register in the register file (32)
//   - RESP_OKAY      : AXI response code for a normal access
//   - RESP_SLVERR    : AXI response code for a slave error
//   - write_state_t  : write-channel FSM states (W_IDLE, W_RESP)
//   - read_state_t   : read-channel FSM states (R_IDLE, R_DATA)
// ---------------------------------------------------------------------------
package axil_resp_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } write_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } read_state_t;

endpackage

// File: rtl/axil_resp_addr_decode.sv
// ---------------------------------------------------------------------------
// axil_resp_addr_decode
// Purely combinational address decoder for the register responder.
// The byte offset from BASE_ADDRESS is computed with 32-bit wrap-around, so
// addresses below the base land far out of range rather than aliasing.
// Ports:
//   addr     in   32      byte address presented on a channel
//   in_range out  1       offset falls inside the register window
//   index    out  IDX_W   register number (offset bits [IDX_W+1:2])
// ---------------------------------------------------------------------------
module axil_resp_addr_decode #(
    parameter logic [31:0] BASE_ADDRESS = 32'h43c00000,
    parameter int          N_REGISTERS  = 8,
    parameter int          IDX_W        = $clog2(N_REGISTERS)
) (
    input  logic [31:0]      addr,
    output logic             in_range,
    output logic [IDX_W-1:0] index
);

    localparam logic [31:0] SPAN = 32'(4 * N_REGISTERS);

    logic [31:0] offset;

    // The two lowest offset bits select a byte inside a register and are
    // deliberately dropped, so unaligned addresses hit the enclosing register.
    always_comb begin
        offset   = addr - BASE_ADDRESS;
        in_range = (offset < SPAN);
        index    = offset[IDX_W+1:2];
    end

endmodule

// File: rtl/axil_reg_responder.sv
// ---------------------------------------------------------------------------
// axil_reg_responder
// AXI4-Lite slave exposing N_REGISTERS 32-bit read/write registers starting
// at BASE_ADDRESS. Write and read channels run independent FSMs.
// Build option: define AXIL_RESP_SLVERR_EN to answer out-of-range accesses
// with SLVERR; by default they complete with OKAY (reads return zero).
// Ports:
//   clock, reset                 sole clock, synchronous active-high reset
//   axi_aw*/axi_w*/axi_b*        write address, write data, write response
//   axi_ar*/axi_r*               read address, read data/response
//   reg_out                      flattened registers, reg k at [32k+31:32k]
//   write_strobe                 one-cycle pulse per register updated
// ---------------------------------------------------------------------------
module axil_reg_responder
    import axil_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h43c00000,
    parameter int          N_REGISTERS  = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [31:0]                    axi_awaddr,
    input  logic                           axi_awvalid,
    output logic                           axi_awready,
    input  logic [31:0]                    axi_wdata,
    input  logic [3:0]                     axi_wstrb,
    input  logic                           axi_wvalid,
    output logic                           axi_wready,
    output logic [1:0]                     axi_bresp,
    output logic                           axi_bvalid,
    input  logic                           axi_bready,
    input  logic [31:0]                    axi_araddr,
    input  logic                           axi_arvalid,
    output logic                           axi_arready,
    output logic [31:0]                    axi_rdata,
    output logic [1:0]                     axi_rresp,
    output logic                           axi_rvalid,
    input  logic                           axi_rready,
    output logic [REG_WIDTH*N_REGISTERS-1:0] reg_out,
    output logic [N_REGISTERS-1:0]         write_strobe
);

    localparam int IDX_W = $clog2(N_REGISTERS);

`ifdef AXIL_RESP_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    write_state_t w_state, w_state_next;
    read_state_t  r_state, r_state_next;

    logic                 aw_latched, w_latched;
    logic [31:0]          aw_addr_q;
    logic [31:0]          w_data_q;
    logic [3:0]           w_strb_q;
    logic                 write_fire, write_done, read_fire;
    logic                 w_in_range, r_in_range;
    logic [IDX_W-1:0]     w_index, r_index;
    logic [REG_WIDTH-1:0] regs [N_REGISTERS];

    axil_resp_addr_decode #(
        .BASE_ADDRESS (BASE_ADDRESS),
        .N_REGISTERS  (N_REGISTERS),
        .IDX_W        (IDX_W)
    ) u_write_decode (
        .addr     (aw_addr_q),
        .in_range (w_in_range),
        .index    (w_index)
    );

    axil_resp_addr_decode #(
        .BASE_ADDRESS (BASE_ADDRESS),
        .N_REGISTERS  (N_REGISTERS),
        .IDX_W        (IDX_W)
    ) u_read_decode (
        .addr     (axi_araddr),
        .in_range (r_in_range),
        .index    (r_index)
    );

    // Ready signals are forced low while reset is held so no handshake can
    // complete during reset; they come back as soon as reset is released.
    assign axi_awready = !reset && (w_state == W_IDLE) && !aw_latched;
    assign axi_wready  = !reset && (w_state == W_IDLE) && !w_latched;
    assign axi_arready = !reset && (r_state == R_IDLE);
    assign axi_bvalid  = (w_state == W_RESP);
    assign axi_rvalid  = (r_state == R_DATA);

    // State registers for both channel FSMs.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    // Write FSM: once both address and data are held, commit the write and
    // present the response until the master takes it.
    always_comb begin
        w_state_next = w_state;
        write_fire   = 1'b0;
        write_done   = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_latched && w_latched) begin
                    write_fire   = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (axi_bready) begin
                    write_done   = 1'b1;
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Read FSM: a single-entry pipeline, address accepted in R_IDLE and the
    // registered data held in R_DATA until the master consumes it.
    always_comb begin
        r_state_next = r_state;
        read_fire    = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (axi_arvalid) begin
                    read_fire    = 1'b1;
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_rready) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // AW and W are captured independently so the master may present them in
    // either order; both latches are released together when the response
    // handshake completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            aw_latched <= 1'b0;
            w_latched  <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else if (write_done) begin
            aw_latched <= 1'b0;
            w_latched  <= 1'b0;
        end else begin
            if (axi_awvalid && axi_awready) begin
                aw_latched <= 1'b1;
                aw_addr_q  <= axi_awaddr;
            end
            if (axi_wvalid && axi_wready) begin
                w_latched <= 1'b1;
                w_data_q  <= axi_wdata;
                w_strb_q  <= axi_wstrb;
            end
        end
    end

    // Register file update and write response. The strobe pulses for any
    // in-range write, even with no byte lanes enabled, so software can use
    // a zero-strobe write as a pure notification.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N_REGISTERS; k++) begin
                regs[k] <= '0;
            end
            write_strobe <= '0;
            axi_bresp    <= RESP_OKAY;
        end else begin
            write_strobe <= '0;
            if (write_fire) begin
                axi_bresp <= w_in_range ? RESP_OKAY : OOR_RESP;
                if (w_in_range) begin
                    write_strobe[w_index] <= 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb_q[b]) begin
                            regs[w_index][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read data capture. Sampling the register array with the same edge that
    // may commit a write means a coincident read sees the old contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            axi_rdata <= '0;
            axi_rresp <= RESP_OKAY;
        end else if (read_fire) begin
            axi_rdata <= r_in_range ? regs[r_index] : '0;
            axi_rresp <= r_in_range ? RESP_OKAY : OOR_RESP;
        end
    end

    // Flatten the register array onto the reg_out bus.
    always_comb begin
        reg_out = '0;
        for (int k = 0; k < N_REGISTERS; k++) begin
            reg_out[REG_WIDTH*k +: REG_WIDTH] = regs[k];
        end
    end

endmodule

// File: tb/tb_axil_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_responder
// Self-checking bench for axil_reg_responder (8 registers at 0x43c00000).
// A table of write/read transactions with hand-computed results is applied
// in a loop, followed by hand-written sequences for a read colliding with a
// write commit and for reset during an open transaction.
// Honours AXIL_RESP_SLVERR_EN for the expected out-of-range response code.
// ---------------------------------------------------------------------------
module tb_axil_reg_responder;

    localparam int N_REGS = 8;

`ifdef AXIL_RESP_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic                  clock = 1'b0;
    logic                  reset;
    logic [31:0]           axi_awaddr;
    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [31:0]           axi_wdata;
    logic [3:0]            axi_wstrb;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [1:0]            axi_bresp;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [31:0]           axi_araddr;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [31:0]           axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [32*N_REGS-1:0]  reg_out;
    logic [N_REGS-1:0]     write_strobe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          w_offset;
        int          hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic [7:0]  exp_strobe;
        string       name;
    } vec_t;

    axil_reg_responder #(
        .BASE_ADDRESS (32'h43c00000),
        .N_REGISTERS  (N_REGS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .axi_awaddr   (axi_awaddr),
        .axi_awvalid  (axi_awvalid),
        .axi_awready  (axi_awready),
        .axi_wdata    (axi_wdata),
        .axi_wstrb    (axi_wstrb),
        .axi_wvalid   (axi_wvalid),
        .axi_wready   (axi_wready),
        .axi_bresp    (axi_bresp),
        .axi_bvalid   (axi_bvalid),
        .axi_bready   (axi_bready),
        .axi_araddr   (axi_araddr),
        .axi_arvalid  (axi_arvalid),
        .axi_arready  (axi_arready),
        .axi_rdata    (axi_rdata),
        .axi_rresp    (axi_rresp),
        .axi_rvalid   (axi_rvalid),
        .axi_rready   (axi_rready),
        .reg_out      (reg_out),
        .write_strobe (write_strobe)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int off, input int hold,
                                input logic [31:0] er, input logic [1:0] eresp,
                                input logic [7:0] es, input string n);
        vec_t v;
        v.is_write   = w;
        v.addr       = a;
        v.wdata      = d;
        v.wstrb      = s;
        v.w_offset   = off;
        v.hold       = hold;
        v.exp_rdata  = er;
        v.exp_resp   = eresp;
        v.exp_strobe = es;
        v.name       = n;
        return v;
    endfunction

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Write transaction: offset > 0 delays W after AW, offset < 0 sends W first.
    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int offset,
                           output logic [1:0] resp, output logic [7:0] strobe_or,
                           output int strobe_cnt);
        int aw_start;
        int w_start;
        int cyc;
        bit aw_done;
        bit w_done;
        bit hs_aw;
        bit hs_w;
        aw_start   = (offset < 0) ? -offset : 0;
        w_start    = (offset > 0) ? offset : 0;
        strobe_or  = '0;
        strobe_cnt = 0;
        resp       = 2'b11;
        aw_done    = 1'b0;
        w_done     = 1'b0;
        cyc        = 0;
        axi_awaddr = addr;
        axi_wdata  = data;
        axi_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            axi_awvalid = !aw_done && (cyc >= aw_start);
            axi_wvalid  = !w_done && (cyc >= w_start);
            #1;
            hs_aw = axi_awvalid && axi_awready;
            hs_w  = axi_wvalid && axi_wready;
            if (write_strobe != '0) begin
                strobe_or |= write_strobe;
                strobe_cnt++;
            end
            nextCycle();
            aw_done |= hs_aw;
            w_done  |= hs_w;
            cyc++;
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            checks++;
            errors++;
            $display("[TB] FAIL write_handshake_timeout: got aw=%0d w=%0d expected both done", aw_done, w_done);
        end
        cyc = 0;
        while (!axi_bvalid && cyc < 20) begin
            if (write_strobe != '0) begin
                strobe_or |= write_strobe;
                strobe_cnt++;
            end
            nextCycle();
            cyc++;
        end
        if (!axi_bvalid) begin
            checks++;
            errors++;
            $display("[TB] FAIL bvalid_timeout: got bvalid=0 expected 1");
        end
        if (write_strobe != '0) begin
            strobe_or |= write_strobe;
            strobe_cnt++;
        end
        resp       = axi_bresp;
        axi_bready = 1'b1;
        nextCycle();
        axi_bready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (write_strobe != '0) begin
                strobe_or |= write_strobe;
                strobe_cnt++;
            end
            nextCycle();
        end
    endtask

    // Read transaction with rready held low for 'hold' cycles once rvalid rises.
    task automatic doRead(input logic [31:0] addr, input int hold,
                          output logic [31:0] rdata, output logic [1:0] resp,
                          output bit stable, output bit single);
        int cyc;
        bit hs;
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        cyc         = 0;
        hs          = 1'b0;
        stable      = 1'b1;
        rdata       = 32'hxxxxxxxx;
        resp        = 2'b11;
        while (!hs && cyc < 20) begin
            #1;
            hs = axi_arready;
            nextCycle();
            cyc++;
        end
        axi_arvalid = 1'b0;
        cyc = 0;
        while (!axi_rvalid && cyc < 20) begin
            nextCycle();
            cyc++;
        end
        if (!axi_rvalid) begin
            checks++;
            errors++;
            $display("[TB] FAIL rvalid_timeout: got rvalid=0 expected 1");
        end
        rdata = axi_rdata;
        resp  = axi_rresp;
        for (int i = 0; i < hold; i++) begin
            nextCycle();
            if (!axi_rvalid || axi_rdata !== rdata || axi_rresp !== resp) begin
                stable = 1'b0;
            end
        end
        axi_rready = 1'b1;
        nextCycle();
        axi_rready = 1'b0;
        single = !axi_rvalid;
        nextCycle();
        if (axi_rvalid) begin
            single = 1'b0;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [1:0]  resp;
        logic [7:0]  strobe_or;
        int          strobe_cnt;
        logic [31:0] rdata;
        bit          stable;
        bit          single;
        if (v.is_write) begin
            doWrite(v.addr, v.wdata, v.wstrb, v.w_offset, resp, strobe_or, strobe_cnt);
            checkOutput({v.name, "_bresp"}, 32'(resp), 32'(v.exp_resp));
            checkOutput({v.name, "_strobe"}, 32'(strobe_or), 32'(v.exp_strobe));
            checkOutput({v.name, "_strobe_cycles"}, 32'(strobe_cnt),
                        (v.exp_strobe != 8'h00) ? 32'd1 : 32'd0);
        end else begin
            doRead(v.addr, v.hold, rdata, resp, stable, single);
            checkOutput({v.name, "_rdata"}, rdata, v.exp_rdata);
            checkOutput({v.name, "_rresp"}, 32'(resp), 32'(v.exp_resp));
            checkOutput({v.name, "_stable"}, 32'(stable), 32'd1);
            checkOutput({v.name, "_single"}, 32'(single), 32'd1);
        end
    endtask

    initial begin
        vec_t        vecs[16];
        logic [31:0] exp_regs[N_REGS];

        vecs[0]  = mk(1, 32'h43c00000, 32'h01234567, 4'hF,  0, 0, 32'h0,        2'b00,   8'h01, "wr_reg0");
        vecs[1]  = mk(0, 32'h43c00000, 32'h0,        4'h0,  0, 0, 32'h01234567, 2'b00,   8'h00, "rd_reg0");
        vecs[2]  = mk(1, 32'h43c00004, 32'hDEADBEEF, 4'hF,  2, 0, 32'h0,        2'b00,   8'h02, "wr_reg1_aw_first");
        vecs[3]  = mk(0, 32'h43c00004, 32'h0,        4'h0,  0, 0, 32'hDEADBEEF, 2'b00,   8'h00, "rd_reg1");
        vecs[4]  = mk(1, 32'h43c00008, 32'h11223344, 4'hF,  0, 0, 32'h0,        2'b00,   8'h04, "wr_reg2_full");
        vecs[5]  = mk(1, 32'h43c00008, 32'hAABBCCDD, 4'h5, -2, 0, 32'h0,        2'b00,   8'h04, "wr_reg2_w_first");
        vecs[6]  = mk(0, 32'h43c00008, 32'h0,        4'h0,  0, 0, 32'h11BB33DD, 2'b00,   8'h00, "rd_reg2_merged");
        vecs[7]  = mk(1, 32'h43c0001C, 32'hCAFEF00D, 4'hF,  1, 0, 32'h0,        2'b00,   8'h80, "wr_reg7");
        vecs[8]  = mk(0, 32'h43c0001C, 32'h0,        4'h0,  0, 5, 32'hCAFEF00D, 2'b00,   8'h00, "rd_reg7_hold5");
        vecs[9]  = mk(1, 32'h43c0000C, 32'hFFFFFFFF, 4'h0,  0, 0, 32'h0,        2'b00,   8'h08, "wr_reg3_nostrb");
        vecs[10] = mk(0, 32'h43c0000C, 32'h0,        4'h0,  0, 0, 32'h00000000, 2'b00,   8'h00, "rd_reg3");
        vecs[11] = mk(1, 32'h43c00020, 32'h12345678, 4'hF,  0, 0, 32'h0,        EXP_OOR, 8'h00, "wr_oor_above");
        vecs[12] = mk(0, 32'h43bffffc, 32'h0,        4'h0,  0, 0, 32'h00000000, EXP_OOR, 8'h00, "rd_oor_below");
        vecs[13] = mk(0, 32'h43c00003, 32'h0,        4'h0,  0, 0, 32'h01234567, 2'b00,   8'h00, "rd_unaligned_reg0");
        vecs[14] = mk(1, 32'h43c00012, 32'h0000A5A5, 4'h3,  0, 0, 32'h0,        2'b00,   8'h10, "wr_unaligned_reg4");
        vecs[15] = mk(0, 32'h43c00010, 32'h0,        4'h0,  0, 0, 32'h0000A5A5, 2'b00,   8'h00, "rd_reg4");

        exp_regs[0] = 32'h01234567;
        exp_regs[1] = 32'hDEADBEEF;
        exp_regs[2] = 32'h11BB33DD;
        exp_regs[3] = 32'h00000000;
        exp_regs[4] = 32'h0000A5A5;
        exp_regs[5] = 32'h00000000;
        exp_regs[6] = 32'h00000000;
        exp_regs[7] = 32'hCAFEF00D;

        reset       = 1'b1;
        axi_awaddr  = '0;
        axi_awvalid = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        axi_araddr  = '0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;

        $display("[TB] reset phase");
        repeat (3) nextCycle();
        checkOutput("rst_awready", 32'(axi_awready), 32'd0);
        checkOutput("rst_wready", 32'(axi_wready), 32'd0);
        checkOutput("rst_arready", 32'(axi_arready), 32'd0);
        checkOutput("rst_bvalid", 32'(axi_bvalid), 32'd0);
        checkOutput("rst_rvalid", 32'(axi_rvalid), 32'd0);
        checkOutput("rst_rdata", axi_rdata, 32'd0);
        checkOutput("rst_strobe", 32'(write_strobe), 32'd0);
        for (int k = 0; k < N_REGS; k++) begin
            checkOutput($sformatf("rst_reg_out%0d", k), reg_out[32*k +: 32], 32'd0);
        end

        reset = 1'b0;
        nextCycle();
        checkOutput("post_rst_awready", 32'(axi_awready), 32'd1);

        $display("[TB] table vectors");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
        end
        for (int k = 0; k < N_REGS; k++) begin
            checkOutput($sformatf("table_reg_out%0d", k), reg_out[32*k +: 32], exp_regs[k]);
        end

        $display("[TB] read colliding with write commit");
        axi_awaddr  = 32'h43c00004;
        axi_wdata   = 32'h55555555;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_araddr  = 32'h43c00004;
        nextCycle();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_arvalid = 1'b1;
        nextCycle();
        axi_arvalid = 1'b0;
        checkOutput("coll_rvalid", 32'(axi_rvalid), 32'd1);
        checkOutput("coll_rdata_old", axi_rdata, 32'hDEADBEEF);
        checkOutput("coll_bvalid", 32'(axi_bvalid), 32'd1);
        checkOutput("coll_strobe", 32'(write_strobe), 32'h02);
        checkOutput("coll_reg1_new", reg_out[63:32], 32'h55555555);
        axi_rready = 1'b1;
        axi_bready = 1'b1;
        nextCycle();
        axi_rready = 1'b0;
        axi_bready = 1'b0;
        checkOutput("coll_rvalid_done", 32'(axi_rvalid), 32'd0);
        checkOutput("coll_bvalid_done", 32'(axi_bvalid), 32'd0);
        checkOutput("coll_strobe_gone", 32'(write_strobe), 32'd0);

        $display("[TB] reset while response pending");
        axi_awaddr  = 32'h43c00014;
        axi_wdata   = 32'h12345678;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        nextCycle();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        nextCycle();
        checkOutput("prerst_bvalid", 32'(axi_bvalid), 32'd1);
        reset = 1'b1;
        nextCycle();
        checkOutput("midrst_bvalid", 32'(axi_bvalid), 32'd0);
        checkOutput("midrst_bresp", 32'(axi_bresp), 32'd0);
        checkOutput("midrst_awready", 32'(axi_awready), 32'd0);
        checkOutput("midrst_strobe", 32'(write_strobe), 32'd0);
        for (int k = 0; k < N_REGS; k++) begin
            checkOutput($sformatf("midrst_reg_out%0d", k), reg_out[32*k +: 32], 32'd0);
        end
        reset = 1'b0;
        nextCycle();
        checkOutput("rel_awready", 32'(axi_awready), 32'd1);
        checkOutput("rel_wready", 32'(axi_wready), 32'd1);
        checkOutput("rel_arready", 32'(axi_arready), 32'd1);

        $display("[TB] reset with only AW latched");
        axi_awaddr  = 32'h43c00018;
        axi_awvalid = 1'b1;
        nextCycle();
        axi_awvalid = 1'b0;
        checkOutput("aw_only_awready", 32'(axi_awready), 32'd0);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        axi_wdata  = 32'hFFFFFFFF;
        axi_wstrb  = 4'hF;
        axi_wvalid = 1'b1;
        nextCycle();
        axi_wvalid = 1'b0;
        checkOutput("aw_cleared_awready", 32'(axi_awready), 32'd1);
        repeat (3) nextCycle();
        checkOutput("aw_cleared_bvalid", 32'(axi_bvalid), 32'd0);
        checkOutput("aw_cleared_reg6", reg_out[32*6 +: 32], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
